reg_swap_ctrl: RTL and testbench
================================

Name: reg_swap_ctrl

Overview:
- Access initiator for the `REG` register file in the quicksort datapath: performs one compare-and-swap or forced swap of two entries per `start`.
- Drives REG's `addr`, `in`, `READ_EN` and `WRITE_EN` ports and consumes REG's `out`.
- The partition engine uses it for every element exchange, so it is the only master of REG while busy.

Parameters:
- `WORD_SIZE`, 16, width of REG data and address.

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request pulse; sampled only in IDLE.
- `cmp_en` input 1: 1 = swap only if `mem[a] > mem[b]`; 0 = unconditional swap.
- `addr_a` input WORD_SIZE: first entry index.
- `addr_b` input WORD_SIZE: second entry index.
- `busy` output 1: high in every non-IDLE state.
- `done` output 1: one-cycle completion pulse.
- `swapped` output 1: result flag; 1 if writes were performed. Held until the next accepted start.
- `reg_addr` output WORD_SIZE: to REG `addr`.
- `reg_in` output WORD_SIZE: to REG `in`.
- `reg_out` input WORD_SIZE: from REG `out`.
- `READ_EN` output 1: to REG `READ_EN`.
- `WRITE_EN` output 1: to REG `WRITE_EN`.

Behaviour:
- REG contract:
  - Write: `mem[addr] <= in` at the posedge where `WRITE_EN=1`.
  - Read: `out <= mem[addr]` at the posedge where `READ_EN=1`; `out` holds otherwise.
  - This block never asserts `READ_EN` and `WRITE_EN` together.
- Reset: async, immediate.
  - State goes to IDLE.
  - `busy`, `done`, `swapped`, `READ_EN`, `WRITE_EN` go to 0.
  - `reg_addr`, `reg_in` and the internal latches `a_l`, `b_l`, `da`, `db` go to 0.
  - Reset mid-operation abandons the operation with no further writes. A partially completed swap (after WR_A) is left as-is.
- Outputs are registered, so the values listed per state are valid throughout that state's cycle.
- FSM (one cycle per state unless noted):
  - IDLE:
    - Enables 0.
    - On `start=1`: latch `addr_a`→`a_l`, `addr_b`→`b_l` and `cmp_en`; clear `swapped`; go to RD_A.
  - RD_A:
    - `READ_EN=1`, `reg_addr=a_l`.
    - Next: RD_B.
  - RD_B:
    - `READ_EN=1`, `reg_addr=b_l`.
    - At the ending edge, `da <= reg_out` (= `mem[a]`).
    - Next: CMP.
  - CMP:
    - Enables 0.
    - At the ending edge, `db <= reg_out` (= `mem[b]`).
    - Swap decision uses `reg_out` directly: swap = (`a_l != b_l`) and (`!cmp_en` or `da > reg_out`), unsigned compare.
    - If swap: go to WR_A. Else: go to DONE.
  - WR_A:
    - `WRITE_EN=1`, `reg_addr=a_l`, `reg_in=db`.
    - Next: WR_B.
  - WR_B:
    - `WRITE_EN=1`, `reg_addr=b_l`, `reg_in=da`.
    - Set `swapped=1`.
    - Next: DONE.
  - DONE:
    - `done=1`, `busy=1`, enables 0.
    - Next: IDLE.
- Latency, counted from the accepting edge:
  - Swap path: `done` is high in the 6th cycle.
  - No-swap path: `done` is high in the 4th cycle.
  - `busy` is high from the accepting edge until the edge that ends DONE.
  - Back-to-back: a `start` in the cycle after DONE is accepted.
- Boundary conditions:
  - `start` while busy is ignored, not queued.
  - Input changes on `addr_a`, `addr_b`, `cmp_en` after acceptance have no effect.
  - `addr_a == addr_b` never writes and gives `swapped=0`.
  - Equal values with `cmp_en=1` give no swap, which keeps the sort stable.
  - Address range: full WORD_SIZE; no bounds checking (REG depth is the caller's responsibility).

Test Plan:
1. Preload REG `mem[0]=23`, `mem[1]=24`, `mem[2]=25`. Forced swap: `start`, `cmp_en=0`, a=0, b=2 → `done` in cycle 6, `swapped=1`; afterwards `mem[0]=25`, `mem[2]=23`, `mem[1]=24`; exactly two `WRITE_EN` cycles.
2. Conditional swap with `mem[0]=30`, `mem[1]=24`: `cmp_en=1`, a=0, b=1 → `swapped=1`, `mem[0]=24`, `mem[1]=30`. Repeat the same request → `swapped=0`, `done` in cycle 4, zero `WRITE_EN` cycles, memory unchanged.
3. Equal values and same index:
   - `mem[1]=mem[2]=24`, `cmp_en=1`, a=1, b=2 → no write, `swapped=0`.
   - a=b=1, `cmp_en=0` → no write, `swapped=0`, `done` in cycle 4.
4. Busy handling: pulse `start` again (a=1, b=2) during WR_A of a swap of 0↔2 → ignored. Only one `done`; only entries 0 and 2 are modified. A `start` in the cycle after `done` is accepted.
5. Reset mid-operation: assert `rst` asynchronously (between edges) during WR_B of a 0↔2 swap with `mem[0]=23`, `mem[2]=25` → `WRITE_EN` drops immediately, all outputs are 0, `mem[0]=25`, `mem[2]=25`. After release, `start` works normally.
6. Protocol check across all tests: an assertion that `READ_EN & WRITE_EN` is never 1, and that `done` is only ever high for exactly one cycle.

Source files
------------

// File: rtl/reg_swap_ctrl.sv
// rtl/reg_swap_ctrl.sv - compare-and-swap access initiator for the REG register file
module reg_swap_ctrl #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cmp_en,
    input  logic [WORD_SIZE-1:0] addr_a,
    input  logic [WORD_SIZE-1:0] addr_b,
    output logic                 busy,
    output logic                 done,
    output logic                 swapped,
    output logic [WORD_SIZE-1:0] reg_addr,
    output logic [WORD_SIZE-1:0] reg_in,
    input  logic [WORD_SIZE-1:0] reg_out,
    output logic                 READ_EN,
    output logic                 WRITE_EN
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CMP,
        WR_A,
        WR_B,
        DONE_S
    } state_t;

    state_t               state;
    logic [WORD_SIZE-1:0] a_l;
    logic [WORD_SIZE-1:0] b_l;
    logic [WORD_SIZE-1:0] da;
    logic [WORD_SIZE-1:0] db;
    logic                 cmp_l;
    logic                 do_swap;

    // In CMP, reg_out already holds mem[b]; db only captures it at the end of CMP.
    assign do_swap = (a_l != b_l) && (!cmp_l || (da > reg_out));

    // Write data is a plain select of latched registers, so it is stable for the whole write cycle.
    assign reg_in = (state == WR_B) ? da : db;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            swapped  <= 1'b0;
            READ_EN  <= 1'b0;
            WRITE_EN <= 1'b0;
            reg_addr <= '0;
            a_l      <= '0;
            b_l      <= '0;
            da       <= '0;
            db       <= '0;
            cmp_l    <= 1'b0;
        end else begin
            done     <= 1'b0;
            READ_EN  <= 1'b0;
            WRITE_EN <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_l      <= addr_a;
                        b_l      <= addr_b;
                        cmp_l    <= cmp_en;
                        swapped  <= 1'b0;
                        busy     <= 1'b1;
                        READ_EN  <= 1'b1;
                        reg_addr <= addr_a;
                        state    <= RD_A;
                    end
                end
                RD_A: begin
                    READ_EN  <= 1'b1;
                    reg_addr <= b_l;
                    state    <= RD_B;
                end
                RD_B: begin
                    da    <= reg_out;
                    state <= CMP;
                end
                CMP: begin
                    db <= reg_out;
                    if (do_swap) begin
                        WRITE_EN <= 1'b1;
                        reg_addr <= a_l;
                        state    <= WR_A;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE_S;
                    end
                end
                WR_A: begin
                    WRITE_EN <= 1'b1;
                    reg_addr <= b_l;
                    swapped  <= 1'b1;
                    state    <= WR_B;
                end
                WR_B: begin
                    done  <= 1'b1;
                    state <= DONE_S;
                end
                DONE_S: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_swap_ctrl.sv
// tb/tb_reg_swap_ctrl.sv - self-checking bench for reg_swap_ctrl with a behavioural REG and swap model
module tb_reg_swap_ctrl;

    localparam int W = 16;
    localparam int DEPTH = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic         cmp_en;
    logic [W-1:0] addr_a;
    logic [W-1:0] addr_b;
    logic         busy;
    logic         done;
    logic         swapped;
    logic [W-1:0] reg_addr;
    logic [W-1:0] reg_in;
    logic [W-1:0] reg_out;
    logic         READ_EN;
    logic         WRITE_EN;

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] exp_mem [DEPTH];
    logic         pl_en;
    logic [3:0]   pl_addr;
    logic [W-1:0] pl_data;

    int n_tests;
    int n_fail;
    int proto_err;
    logic prev_done;

    reg_swap_ctrl #(.WORD_SIZE(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmp_en   (cmp_en),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .busy     (busy),
        .done     (done),
        .swapped  (swapped),
        .reg_addr (reg_addr),
        .reg_in   (reg_in),
        .reg_out  (reg_out),
        .READ_EN  (READ_EN),
        .WRITE_EN (WRITE_EN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // REG file model; the bench preload port shares the write path while the DUT is idle
    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (WRITE_EN)
            mem[reg_addr[3:0]] <= reg_in;
        if (READ_EN)
            reg_out <= mem[reg_addr[3:0]];
    end

    always @(negedge clk) begin
        if (READ_EN && WRITE_EN)
            proto_err <= proto_err + 1;
        if (done && prev_done)
            proto_err <= proto_err + 1;
        prev_done <= done;
    end

    assert property (@(posedge clk) disable iff (rst) !(READ_EN && WRITE_EN))
        else $error("FAIL proto_rw: READ_EN and WRITE_EN both high");
    assert property (@(posedge clk) disable iff (rst) done |=> !done)
        else $error("FAIL proto_done: done high for more than one cycle");

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic preload(input int a, input int v);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = 4'(a);
        pl_data = W'(v);
        @(negedge clk);
        pl_en = 1'b0;
        exp_mem[a] = W'(v);
    endtask

    task automatic check_mem(input string tag);
        int diffs;
        diffs = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== exp_mem[i]) diffs++;
        check(tag, diffs, 0);
    endtask

    // One request; glitch > 0 drives a stray start (a=1, b=2) in that cycle of the operation
    task automatic run_op(input int a, input int b, input bit cmp, input int glitch);
        int  cyc;
        int  writes;
        bit  exp_swap;
        int  exp_cyc;
        logic [W-1:0] t;
        @(negedge clk);
        check("idle_busy", busy, 0);
        addr_a = W'(a);
        addr_b = W'(b);
        cmp_en = cmp;
        start  = 1'b1;
        exp_swap = (a != b) && (!cmp || (exp_mem[a] > exp_mem[b]));
        exp_cyc  = exp_swap ? 6 : 4;
        @(negedge clk);
        start  = 1'b0;
        addr_a = W'($urandom);
        addr_b = W'($urandom);
        cmp_en = 1'($urandom);
        cyc    = 1;
        writes = 0;
        check("rd_a_en", READ_EN, 1);
        check("rd_a_addr", reg_addr, a);
        check("busy_run", busy, 1);
        while (!done && cyc < 12) begin
            if (WRITE_EN) writes++;
            if (cyc == glitch) begin
                start  = 1'b1;
                addr_a = 1;
                addr_b = 2;
                cmp_en = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_cyc", cyc, exp_cyc);
        check("done_busy", busy, 1);
        check("swapped", swapped, exp_swap);
        check("writes", writes, exp_swap ? 2 : 0);
        if (exp_swap) begin
            t = exp_mem[a];
            exp_mem[a] = exp_mem[b];
            exp_mem[b] = t;
        end
        check_mem("mem");
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        proto_err = 0;
        prev_done = 1'b0;
        rst = 1'b0;
        start = 1'b0;
        cmp_en = 1'b0;
        addr_a = '0;
        addr_b = '0;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_swapped", swapped, 0);
        check("rst_re", READ_EN, 0);
        check("rst_we", WRITE_EN, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_in", reg_in, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) preload(i, 100 + i);

        // forced swap 0<->2
        preload(0, 23); preload(1, 24); preload(2, 25);
        run_op(0, 2, 1'b0, 0);
        check("t1_m0", mem[0], 25);
        check("t1_m2", mem[2], 23);

        // conditional swap then repeat (no swap)
        preload(0, 30); preload(1, 24);
        run_op(0, 1, 1'b1, 0);
        check("t2_m0", mem[0], 24);
        run_op(0, 1, 1'b1, 0);

        // equal values and same index
        preload(1, 24); preload(2, 24);
        run_op(1, 2, 1'b1, 0);
        run_op(1, 1, 1'b0, 0);

        // stray start during WR_A is ignored; immediate follow-up is accepted
        preload(0, 23); preload(1, 24); preload(2, 25);
        run_op(0, 2, 1'b0, 4);
        run_op(0, 1, 1'b0, 0);
        begin
            int extra;
            extra = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (done || busy) extra++;
            end
            check("no_queue", extra, 0);
        end

        // asynchronous reset during WR_B
        preload(0, 23); preload(2, 25);
        @(negedge clk);
        addr_a = 0; addr_b = 2; cmp_en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("wrb_we", WRITE_EN, 1);
        check("wrb_addr", reg_addr, 2);
        #2 rst = 1'b1;
        #1;
        check("mid_we", WRITE_EN, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_swapped", swapped, 0);
        check("mid_re", READ_EN, 0);
        check("mid_addr", reg_addr, 0);
        check("mid_in", reg_in, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_mem[0] = 25;
        check_mem("mid_mem");
        preload(3, 7);
        run_op(3, 0, 1'b1, 0);

        // randomized requests against the swap model
        for (int n = 0; n < 150; n++) begin
            int gl;
            if ($urandom_range(0, 3) == 0)
                preload($urandom_range(0, 7), $urandom_range(0, 20));
            gl = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 3) : 0;
            run_op($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)), gl);
        end

        @(negedge clk);
        check("protocol", proto_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
